// File: rtl/tl_a_client_arbiter.sv
// Two-client TileLink-UH A-channel arbiter: keeps multi-beat messages atomic,
// alternates clients round-robin at message boundaries, routes D back by source bit 5.
module tl_a_client_arbiter (
  input  logic         clock,
  input  logic         reset,

  input  logic         in0_a_valid,
  output logic         in0_a_ready,
  input  logic [2:0]   in0_a_bits_opcode,
  input  logic [2:0]   in0_a_bits_param,
  input  logic [2:0]   in0_a_bits_size,
  input  logic [4:0]   in0_a_bits_source,
  input  logic [31:0]  in0_a_bits_address,
  input  logic [15:0]  in0_a_bits_mask,
  input  logic [127:0] in0_a_bits_data,
  input  logic         in0_a_bits_corrupt,

  input  logic         in1_a_valid,
  output logic         in1_a_ready,
  input  logic [2:0]   in1_a_bits_opcode,
  input  logic [2:0]   in1_a_bits_param,
  input  logic [2:0]   in1_a_bits_size,
  input  logic [4:0]   in1_a_bits_source,
  input  logic [31:0]  in1_a_bits_address,
  input  logic [15:0]  in1_a_bits_mask,
  input  logic [127:0] in1_a_bits_data,
  input  logic         in1_a_bits_corrupt,

  output logic         out_a_valid,
  input  logic         out_a_ready,
  output logic [2:0]   out_a_bits_opcode,
  output logic [2:0]   out_a_bits_param,
  output logic [2:0]   out_a_bits_size,
  output logic [5:0]   out_a_bits_source,
  output logic [31:0]  out_a_bits_address,
  output logic [15:0]  out_a_bits_mask,
  output logic [127:0] out_a_bits_data,
  output logic         out_a_bits_corrupt,

  input  logic         out_d_valid,
  output logic         out_d_ready,
  input  logic [2:0]   out_d_bits_opcode,
  input  logic [1:0]   out_d_bits_param,
  input  logic [2:0]   out_d_bits_size,
  input  logic [5:0]   out_d_bits_source,
  input  logic [3:0]   out_d_bits_sink,
  input  logic         out_d_bits_denied,
  input  logic [127:0] out_d_bits_data,
  input  logic         out_d_bits_corrupt,

  output logic         in0_d_valid,
  input  logic         in0_d_ready,
  output logic [2:0]   in0_d_bits_opcode,
  output logic [1:0]   in0_d_bits_param,
  output logic [2:0]   in0_d_bits_size,
  output logic [4:0]   in0_d_bits_source,
  output logic [3:0]   in0_d_bits_sink,
  output logic         in0_d_bits_denied,
  output logic [127:0] in0_d_bits_data,
  output logic         in0_d_bits_corrupt,

  output logic         in1_d_valid,
  input  logic         in1_d_ready,
  output logic [2:0]   in1_d_bits_opcode,
  output logic [1:0]   in1_d_bits_param,
  output logic [2:0]   in1_d_bits_size,
  output logic [4:0]   in1_d_bits_source,
  output logic [3:0]   in1_d_bits_sink,
  output logic         in1_d_bits_denied,
  output logic [127:0] in1_d_bits_data,
  output logic         in1_d_bits_corrupt
);

  logic       locked;
  logic       owner;
  logic       prio;
  logic [2:0] beats_left;

  logic       grant;
  logic       has_grant;
  logic       fire;
  logic       last_beat;
  logic [3:0] msg_beats;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    grant = 1'b0;
    if (locked)                         grant = owner;
    else if (in0_a_valid && in1_a_valid) grant = prio;
    else if (in1_a_valid)               grant = 1'b1;
  end

  assign has_grant = locked | in0_a_valid | in1_a_valid;

  // Valid comes only from the selected client, never from out_a_ready.
  assign out_a_valid        = grant ? in1_a_valid        : in0_a_valid;
  assign out_a_bits_opcode  = grant ? in1_a_bits_opcode  : in0_a_bits_opcode;
  assign out_a_bits_param   = grant ? in1_a_bits_param   : in0_a_bits_param;
  assign out_a_bits_size    = grant ? in1_a_bits_size    : in0_a_bits_size;
  assign out_a_bits_source  = {grant, grant ? in1_a_bits_source : in0_a_bits_source};
  assign out_a_bits_address = grant ? in1_a_bits_address : in0_a_bits_address;
  assign out_a_bits_mask    = grant ? in1_a_bits_mask    : in0_a_bits_mask;
  assign out_a_bits_data    = grant ? in1_a_bits_data    : in0_a_bits_data;
  assign out_a_bits_corrupt = grant ? in1_a_bits_corrupt : in0_a_bits_corrupt;

  assign in0_a_ready = out_a_ready & has_grant & ~grant;
  assign in1_a_ready = out_a_ready & has_grant & grant;

  // Data-carrying opcodes (0..3) larger than one 16-byte beat span 2, 4 or 8 beats.
  always_comb begin
    msg_beats = 4'd1;
    if (!out_a_bits_opcode[2] && out_a_bits_size > 3'd4)
      msg_beats = 4'd1 << (out_a_bits_size - 3'd4);
  end

  assign fire      = out_a_valid & out_a_ready;
  assign last_beat = locked ? (beats_left == 3'd1) : (msg_beats == 4'd1);

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      locked     <= 1'b0;
      owner      <= 1'b0;
      prio       <= 1'b0;
      beats_left <= 3'd0;
    end else if (fire) begin
      if (locked) begin
        beats_left <= beats_left - 3'd1;
        if (beats_left == 3'd1) locked <= 1'b0;
      end else if (msg_beats != 4'd1) begin
        locked     <= 1'b1;
        owner      <= grant;
        beats_left <= 3'(msg_beats - 4'd1);
      end
      if (last_beat) prio <= ~grant;
    end
  end

  // D channel: stateless steering on the client bit prepended to the source.
  assign in0_d_valid = out_d_valid & ~out_d_bits_source[5];
  assign in1_d_valid = out_d_valid &  out_d_bits_source[5];
  assign out_d_ready = out_d_bits_source[5] ? in1_d_ready : in0_d_ready;

  assign in0_d_bits_opcode  = out_d_bits_opcode;
  assign in0_d_bits_param   = out_d_bits_param;
  assign in0_d_bits_size    = out_d_bits_size;
  assign in0_d_bits_source  = out_d_bits_source[4:0];
  assign in0_d_bits_sink    = out_d_bits_sink;
  assign in0_d_bits_denied  = out_d_bits_denied;
  assign in0_d_bits_data    = out_d_bits_data;
  assign in0_d_bits_corrupt = out_d_bits_corrupt;

  assign in1_d_bits_opcode  = out_d_bits_opcode;
  assign in1_d_bits_param   = out_d_bits_param;
  assign in1_d_bits_size    = out_d_bits_size;
  assign in1_d_bits_source  = out_d_bits_source[4:0];
  assign in1_d_bits_sink    = out_d_bits_sink;
  assign in1_d_bits_denied  = out_d_bits_denied;
  assign in1_d_bits_data    = out_d_bits_data;
  assign in1_d_bits_corrupt = out_d_bits_corrupt;

endmodule
